// File: rtl/fwd_ctrl_if.sv
// Handshake bundle between the ID/EX decode fields and the forwarding/hazard controller.
// The master drives the decoded ID fields; the slave (fwd_ctrl) returns the mux selects and stall.
interface fwd_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  i_id_valid;
  logic [REG_ADDR_W-1:0] i_id_rs1;
  logic [REG_ADDR_W-1:0] i_id_rs2;
  logic [REG_ADDR_W-1:0] i_id_rd;
  logic                  i_id_regwrite;
  logic                  i_id_memread;
  logic                  i_flush;
  logic                  i_stall_ext;
  logic [1:0]            o_fwd_a;
  logic [1:0]            o_fwd_b;
  logic                  o_stall;
  logic                  o_ex_valid;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_regwrite, i_id_memread,
    output i_flush, i_stall_ext,
    input  o_fwd_a, o_fwd_b, o_stall, o_ex_valid
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_regwrite, i_id_memread,
    input  i_flush, i_stall_ext,
    output o_fwd_a, o_fwd_b, o_stall, o_ex_valid
  );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: shadows rd through EX/MEM/WB(/PWB) and drives EX mux selects.
// Optional macro FWD_POSTWB_EN adds the post-WB stage and the 2'b11 (held result) select.
module fwd_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  fwd_ctrl_if.slave  bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_PWB = 2'b11;

  // p0 = EX, p1 = MEM, p2 = WB, p3 = post-WB
  logic                  r_vld_p0, r_regwrite_p0, r_memread_p0;
  logic [REG_ADDR_W-1:0] r_rd_p0, r_rs1_p0, r_rs2_p0;
  logic                  r_vld_p1, r_regwrite_p1, r_memread_p1;
  logic [REG_ADDR_W-1:0] r_rd_p1;
  logic                  r_vld_p2, r_regwrite_p2;
  logic [REG_ADDR_W-1:0] r_rd_p2;
`ifdef FWD_POSTWB_EN
  logic                  r_vld_p3, r_regwrite_p3;
  logic [REG_ADDR_W-1:0] r_rd_p3;
`endif

  logic       w_stall;
  logic       w_ex_load;
  logic       w_mem_a, w_mem_b, w_wb_a, w_wb_b, w_pwb_a, w_pwb_b;

  function automatic logic f_match(input logic vld, input logic rw,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return vld & rw & (rd != '0) & (rd == rs);
  endfunction

  function automatic logic [1:0] f_sel(input logic ex_vld, input logic m_mem,
                                       input logic m_wb, input logic m_pwb);
    if (!ex_vld)    return SEL_RF;
    else if (m_mem) return SEL_MEM;
    else if (m_wb)  return SEL_WB;
    else if (m_pwb) return SEL_PWB;
    else            return SEL_RF;
  endfunction

  assign w_stall = bus.i_id_valid & ~bus.i_flush & r_vld_p0 & r_memread_p0 &
                   (r_rd_p0 != '0) &
                   ((r_rd_p0 == bus.i_id_rs1) | (r_rd_p0 == bus.i_id_rs2));
  assign w_ex_load = bus.i_id_valid & ~w_stall & ~bus.i_flush;

  // A load in MEM only has its address on the EX/MEM bus, so it is never a forwarding source.
  assign w_mem_a = f_match(r_vld_p1 & ~r_memread_p1, r_regwrite_p1, r_rd_p1, r_rs1_p0);
  assign w_mem_b = f_match(r_vld_p1 & ~r_memread_p1, r_regwrite_p1, r_rd_p1, r_rs2_p0);
  assign w_wb_a  = f_match(r_vld_p2, r_regwrite_p2, r_rd_p2, r_rs1_p0);
  assign w_wb_b  = f_match(r_vld_p2, r_regwrite_p2, r_rd_p2, r_rs2_p0);
`ifdef FWD_POSTWB_EN
  assign w_pwb_a = f_match(r_vld_p3, r_regwrite_p3, r_rd_p3, r_rs1_p0);
  assign w_pwb_b = f_match(r_vld_p3, r_regwrite_p3, r_rd_p3, r_rs2_p0);
`else
  assign w_pwb_a = 1'b0;
  assign w_pwb_b = 1'b0;
`endif

  assign bus.o_fwd_a    = f_sel(r_vld_p0, w_mem_a, w_wb_a, w_pwb_a);
  assign bus.o_fwd_b    = f_sel(r_vld_p0, w_mem_b, w_wb_b, w_pwb_b);
  assign bus.o_stall    = w_stall;
  assign bus.o_ex_valid = r_vld_p0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p0      <= 1'b0;
      r_regwrite_p0 <= 1'b0;
      r_memread_p0  <= 1'b0;
      r_rd_p0       <= '0;
      r_rs1_p0      <= '0;
      r_rs2_p0      <= '0;
      r_vld_p1      <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_rd_p1       <= '0;
      r_vld_p2      <= 1'b0;
      r_regwrite_p2 <= 1'b0;
      r_rd_p2       <= '0;
`ifdef FWD_POSTWB_EN
      r_vld_p3      <= 1'b0;
      r_regwrite_p3 <= 1'b0;
      r_rd_p3       <= '0;
`endif
    end else if (!bus.i_stall_ext) begin
`ifdef FWD_POSTWB_EN
      r_vld_p3      <= r_vld_p2;
      r_regwrite_p3 <= r_regwrite_p2;
      r_rd_p3       <= r_rd_p2;
`endif
      r_vld_p2      <= r_vld_p1;
      r_regwrite_p2 <= r_regwrite_p1;
      r_rd_p2       <= r_rd_p1;
      r_vld_p1      <= r_vld_p0;
      r_regwrite_p1 <= r_regwrite_p0;
      r_memread_p1  <= r_memread_p0;
      r_rd_p1       <= r_rd_p0;
      // Stalled, flushed or empty slots enter EX as a fully zeroed bubble.
      r_vld_p0      <= w_ex_load;
      r_regwrite_p0 <= w_ex_load & bus.i_id_regwrite;
      r_memread_p0  <= w_ex_load & bus.i_id_memread;
      r_rd_p0       <= w_ex_load ? bus.i_id_rd  : '0;
      r_rs1_p0      <= w_ex_load ? bus.i_id_rs1 : '0;
      r_rs2_p0      <= w_ex_load ? bus.i_id_rs2 : '0;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: hand-computed selects/stall for ALU, load-use, x0, flush and freeze cases.
module tb_fwd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  fwd_ctrl_if #(.REG_ADDR_W(5)) bus ();

  fwd_ctrl #(.REG_ADDR_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

`ifdef FWD_POSTWB_EN
  localparam logic [1:0] EXP_TWO_NOPS = 2'b11;
`else
  localparam logic [1:0] EXP_TWO_NOPS = 2'b00;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    bus.i_id_valid    = v;
    bus.i_id_rs1      = rs1;
    bus.i_id_rs2      = rs2;
    bus.i_id_rd       = rd;
    bus.i_id_regwrite = rw;
    bus.i_id_memread  = mr;
    bus.i_flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (5) tick();
  endtask

  // Invariant: a load sitting in MEM must never be a match for the live EX instruction.
  always @(negedge clk) begin
    if (rst_n && dut.r_vld_p0 && dut.r_vld_p1 && dut.r_memread_p1 && dut.r_regwrite_p1 &&
        dut.r_rd_p1 != 5'd0) begin
      n_checks++;
      assert (!(dut.r_rd_p1 == dut.r_rs1_p0 || dut.r_rd_p1 == dut.r_rs2_p0)) else begin
        n_err++;
        $error("FAIL mem_load_match observed=1 expected=0");
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.i_stall_ext = 1'b0;
    idle();

    // Reset then idle
    tick();
    #1 chk("reset_outputs", {4'd0, bus.o_fwd_a, bus.o_fwd_b, bus.o_stall, bus.o_ex_valid}, 8'h00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1 chk("idle_outputs", {2'd0, bus.o_fwd_a, bus.o_fwd_b, bus.o_stall, bus.o_ex_valid}, 8'h00);
    end

    // add x5 ; sub x6,x5,x5
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("b2b_fwd_a", bus.o_fwd_a, 2'b10);
    chk("b2b_fwd_b", bus.o_fwd_b, 2'b10);
    chk("b2b_ex_valid", bus.o_ex_valid, 1'b1);
    drain();

    // add x5 ; nop ; sub
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    #1 chk("nop_in_ex", {bus.o_fwd_a, bus.o_fwd_b, bus.o_ex_valid}, 5'b00000);
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("one_nop_fwd_a", bus.o_fwd_a, 2'b01);
    chk("one_nop_fwd_b", bus.o_fwd_b, 2'b01);
    drain();

    // add x5 ; nop ; nop ; sub
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("two_nop_fwd_a", bus.o_fwd_a, EXP_TWO_NOPS);
    chk("two_nop_fwd_b", bus.o_fwd_b, EXP_TWO_NOPS);
    chk("two_nop_ex_valid", bus.o_ex_valid, 1'b1);
    drain();

    // lw x7 ; add x8,x7,x0 : one-cycle stall, bubble, then WB forward
    drive(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", bus.o_stall, 1'b1);
    tick();
    #1;
    chk("lu_stall_drop", bus.o_stall, 1'b0);
    chk("lu_bubble", bus.o_ex_valid, 1'b0);
    tick();
    idle();
    #1;
    chk("lu_ex_valid", bus.o_ex_valid, 1'b1);
    chk("lu_fwd_a", bus.o_fwd_a, 2'b01);
    chk("lu_fwd_b", bus.o_fwd_b, 2'b00);
    chk("lu_no_stall", bus.o_stall, 1'b0);
    drain();

    // add x3 ; or x3 ; and x9,x1,x3 : younger MEM producer wins
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("dbl_fwd_b", bus.o_fwd_b, 2'b10);
    chk("dbl_fwd_a", bus.o_fwd_a, 2'b00);
    drain();

    // x0 writer then x0 reader
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("x0_fwd_a", bus.o_fwd_a, 2'b00);
    chk("x0_ex_valid", bus.o_ex_valid, 1'b1);
    drain();

    // lw x0 never stalls
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    #1 chk("x0_load_no_stall", bus.o_stall, 1'b0);
    drain();

    // lw x4 ; flushed reader of x4
    drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd4, 5'd12, 1'b1, 1'b0, 1'b1);
    #1 chk("flush_no_stall", bus.o_stall, 1'b0);
    tick();
    idle();
    #1 chk("flush_bubble", bus.o_ex_valid, 1'b0);
    drain();

    // External freeze with add->sub in flight
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1 chk("frz_pre_fwd_a", bus.o_fwd_a, 2'b10);
    bus.i_stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 chk("frz_hold", {3'd0, bus.o_fwd_a, bus.o_fwd_b, bus.o_ex_valid}, {3'd0, 5'b10101});
    end
    bus.i_stall_ext = 1'b0;
    drive(1'b1, 5'd6, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0);
    #1 chk("frz_release_fwd_a", bus.o_fwd_a, 2'b10);
    tick();
    idle();
    #1;
    chk("frz_resume_fwd_a", bus.o_fwd_a, 2'b10);
    chk("frz_resume_fwd_b", bus.o_fwd_b, 2'b01);
    drain();

    // Reset mid-operation discards the pending load
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    chk("midrst_ex_valid", bus.o_ex_valid, 1'b0);
    chk("midrst_no_stall", bus.o_stall, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

- Forwarding and hazard controller for the 5-stage pipeline.
- Keeps a shadow scoreboard of destination registers as they move from EX to MEM to WB (and one stage past WB).
- Generates the 2-bit operand-select codes that drive the two EX-stage 4:1 forwarding muxes, and raises the load-use stall toward IF/ID.
- Sits beside the ID/EX pipeline register and consumes the decoded fields of the instruction leaving ID.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- Select encoding (fixed): 2'b00 regfile, 2'b01 WB result, 2'b10 MEM (EX/MEM ALU) result, 2'b11 post-WB (held) result

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  synchronous, active-low reset
- i_id_valid  input  1  an instruction is leaving ID this cycle
- i_id_rs1  input  REG_ADDR_W  source register 1 of the ID instruction
- i_id_rs2  input  REG_ADDR_W  source register 2 of the ID instruction
- i_id_rd  input  REG_ADDR_W  destination register of the ID instruction
- i_id_regwrite  input  1  ID instruction writes rd
- i_id_memread  input  1  ID instruction is a load
- i_flush  input  1  kill the instruction leaving ID (taken branch)
- i_stall_ext  input  1  global freeze (memory wait)
- o_fwd_a  output  2  select for EX operand A mux
- o_fwd_b  output  2  select for EX operand B mux
- o_stall  output  1  load-use stall: hold PC and IF/ID
- o_ex_valid  output  1  EX stage holds a live instruction

## Operation
- Shadow stages, each holding valid, rd and regwrite:
  - EX: also holds rs1, rs2 and memread.
  - MEM: also holds memread.
  - WB.
  - PWB (post-WB).
- Stage advance when i_stall_ext=0:
  - PWB<=WB, WB<=MEM, MEM<=EX.
  - EX<=ID fields, with valid = i_id_valid & ~o_stall & ~i_flush.
- A bubble enters EX as valid=0, with all other fields zeroed.
- When i_stall_ext=1, every stage holds its value. o_stall is still computed but has no effect on state.
- Producer match for stage S and operand rsX: S.valid & S.regwrite & (S.rd != 0) & (S.rd == EX.rsX).
- Select priority per operand: MEM match -> 10, else WB match -> 01, else PWB match -> 11, else 00.
- When EX.valid=0, both selects are 00.
- A MEM match where MEM.memread=1 cannot occur, because the stall guarantees this. The bench asserts it never happens.
- Load-use stall: o_stall = i_id_valid & EX.valid & EX.memread & (EX.rd != 0) & ((EX.rd == i_id_rs1) | (EX.rd == i_id_rs2)).
- i_flush forces o_stall=0, so flush wins over stall.
- x0 never forwards and never stalls.

## Timing
- Reset (i_rst_n=0 at an edge):
  - All valid bits 0 and all fields 0.
  - o_fwd_a = o_fwd_b = 00, o_stall = 0, o_ex_valid = 0.
- Reset mid-operation discards all in-flight state on that edge.
- o_fwd_a, o_fwd_b and o_ex_valid are combinational from registered state. They are valid in the same cycle the instruction occupies EX.
- o_stall is combinational from the ID inputs and the EX register, in the same cycle the instruction is in ID.
- A stall lasts exactly one cycle per load-use pair:
  - The next cycle, the load is in MEM and EX holds the bubble, so o_stall deasserts.
  - The dependent instruction then reaches EX while the load is in WB, so its select is 01.
- Simultaneous producers in MEM and WB with the same rd: MEM wins, because it is the younger instruction.
- During i_stall_ext, outputs remain constant. No stage advances.

## Configuration
- FWD_POSTWB_EN defined:
  - The PWB stage is implemented and select 11 is produced.
  - Used with a regfile that writes at the end of WB and reads old data in the same cycle.
- FWD_POSTWB_EN undefined:
  - There is no PWB stage and 11 is never driven.
  - The regfile is write-first, so a WB-stage producer still yields 01, and older producers fall to 00.

## Test plan
- Reset then idle:
  - Stimulus: hold i_rst_n=0 for 2 cycles, then keep i_id_valid=0.
  - Required: all outputs 0 for 10 cycles.
- Back-to-back ALU dependency:
  - Stimulus: add x5 (rd=5, regwrite) followed by sub using rs1=5, rs2=5.
  - Required: o_fwd_a = o_fwd_b = 10 when sub is in EX.
  - With a nop inserted between them: 01.
  - With two nops, under FWD_POSTWB_EN: 11; otherwise 00.
- Load-use:
  - Stimulus: lw rd=7 (memread) followed by add rs1=7.
  - Required: o_stall=1 for exactly 1 cycle, then o_ex_valid=0 for one cycle (bubble), then o_fwd_a=01 for the add.
- Double producer:
  - Stimulus: add rd=3, then or rd=3, then and rs2=3.
  - Required: o_fwd_b=10 (the or, in MEM), not 01.
- x0 and flush:
  - Stimulus 1: rd=0 writer followed by rs1=0 reader.
  - Required: o_fwd_a=00.
  - Stimulus 2: lw rd=4 followed by a reader of x4 with i_flush=1.
  - Required: o_stall=0 and o_ex_valid=0 next cycle.
- External freeze:
  - Stimulus: assert i_stall_ext for 3 cycles while the add->sub pair is in flight.
  - Required: o_fwd_a stays 10 throughout; after release, the sequence resumes unchanged.
